// File: rtl/idct_transpose_ctrl.sv
// -----------------------------------------------------------------------------
// idct_transpose_ctrl
//
// Purpose: buffer controller sitting between the two 1-D IDCT passes. It fills
// an external 64x16 buffer with one 8x8 block in row-major order, then drains
// it through a 2-entry output FIFO, either in the same order or transposed
// (column-major).
//
// Build option: define TRANSPOSE_EN for column-major (transposed) read order.
// Without it the block passes through in row-major order; timing is identical.
//
// Ports:
//   clk             clock, all logic on the rising edge
//   rst_b           synchronous active-low reset
//   in_valid        upstream coefficient valid
//   in_data[15:0]   upstream coefficient, row-major order
//   in_ready        block accepts in_data this cycle (high while filling)
//   out_valid       output word valid
//   out_data[15:0]  output word
//   out_last        marks the 64th word of a block
//   out_ready       downstream accepts out_data this cycle
//   mem_addr[5:0]   buffer address
//   mem_data_in     buffer write data (0 whenever not writing)
//   mem_write_read  buffer mode: 0 write, 1 read
//   mem_data_out    buffer read data, valid one cycle after a read is issued
//
// The buffer reads (and clears) whatever address it sees whenever
// mem_write_read=1, so idle cycles must point at a harmless address: while
// filling that is the next address to be written, while draining it is the
// last address already read.
// -----------------------------------------------------------------------------
module idct_transpose_ctrl (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic        out_last,
  input  logic        out_ready,
  output logic [5:0]  mem_addr,
  output logic [15:0] mem_data_in,
  output logic        mem_write_read,
  input  logic [15:0] mem_data_out
);

  typedef enum logic {
    ST_WRITE = 1'b0,
    ST_READ  = 1'b1
  } state_t;

  state_t      state_reg;
  logic [5:0]  wcnt_reg;
  logic [6:0]  rcnt_reg;          // bit 6 set once all 64 reads are issued
  logic [5:0]  last_raddr_reg;
  logic        inflight_reg;      // a read was issued last cycle
  logic        inflight_last_reg; // ...and it was the 64th of the block
  logic        rd_ptr_reg;
  logic        wr_ptr_reg;
  logic [1:0]  count_reg;         // FIFO occupancy, 0..2

  logic        accept;
  logic        pop;
  logic        push;
  logic        issue;
  logic [1:0]  pending;
  logic [5:0]  raddr_cur;
  logic [15:0] head_data;
  logic        head_last;

  // Read-order mapping from read count to buffer address.
  function automatic logic [5:0] raddr(input logic [5:0] idx);
`ifdef TRANSPOSE_EN
    return {idx[2:0], idx[5:3]};
`else
    return idx;
`endif
  endfunction

  assign in_ready  = (state_reg == ST_WRITE);
  assign accept    = in_ready && in_valid;
  assign out_valid = (count_reg != 2'd0);
  assign pop       = out_valid && out_ready;
  assign push      = inflight_reg;
  assign raddr_cur = raddr(rcnt_reg[5:0]);

  // Slots that will be in use next cycle if nothing new is issued. Counting
  // the pop this cycle is what lets reads issue back-to-back at 1 word/cycle.
  assign pending = count_reg + {1'b0, inflight_reg} - {1'b0, pop};
  assign issue   = (state_reg == ST_READ) && !rcnt_reg[6] && (pending < 2'd2);

  // Buffer port: write only on an accepted beat; otherwise always a read.
  assign mem_write_read = !accept;
  assign mem_data_in    = accept ? in_data : 16'd0;
  assign mem_addr       = (state_reg == ST_WRITE) ? wcnt_reg :
                          (issue ? raddr_cur : last_raddr_reg);

  // Two FIFO entries, each captured directly from the buffer return port.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      logic [15:0] entry_data_reg;
      logic        entry_last_reg;

      always_ff @(posedge clk) begin
        if (!rst_b) begin
          entry_data_reg <= 16'd0;
          entry_last_reg <= 1'b0;
        end else if (push && (wr_ptr_reg == 1'(gi))) begin
          entry_data_reg <= mem_data_out;
          entry_last_reg <= inflight_last_reg;
        end
      end
    end
  endgenerate

  assign head_data = rd_ptr_reg ? g_fifo[1].entry_data_reg : g_fifo[0].entry_data_reg;
  assign head_last = rd_ptr_reg ? g_fifo[1].entry_last_reg : g_fifo[0].entry_last_reg;
  assign out_data  = out_valid ? head_data : 16'd0;
  assign out_last  = out_valid && head_last;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_reg         <= ST_WRITE;
      wcnt_reg          <= 6'd0;
      rcnt_reg          <= 7'd0;
      last_raddr_reg    <= 6'd0;
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
      rd_ptr_reg        <= 1'b0;
      wr_ptr_reg        <= 1'b0;
      count_reg         <= 2'd0;
    end else begin
      inflight_reg      <= issue;
      inflight_last_reg <= issue && (rcnt_reg[5:0] == 6'd63);
      if (issue) begin
        rcnt_reg       <= rcnt_reg + 7'd1;
        last_raddr_reg <= raddr_cur;
      end
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_reg + {1'b0, push} - {1'b0, pop};

      case (state_reg)
        ST_WRITE: begin
          if (accept) begin
            wcnt_reg <= wcnt_reg + 6'd1;
            if (wcnt_reg == 6'd63) begin
              state_reg <= ST_READ;
              wcnt_reg  <= 6'd0;
            end
          end
        end
        ST_READ: begin
          // Last word leaving: nothing is in flight and the FIFO holds only
          // this word, so a clean restart of the read side is safe.
          if (pop && head_last) begin
            state_reg  <= ST_WRITE;
            rcnt_reg   <= 7'd0;
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
          end
        end
        default: state_reg <= ST_WRITE;
      endcase
    end
  end

endmodule

// File: tb/tb_idct_transpose_ctrl.sv
// -----------------------------------------------------------------------------
// tb_idct_transpose_ctrl
//
// Bench for idct_transpose_ctrl: contains a behavioural 64x16 buffer (write on
// 0, read-and-clear on 1, one-cycle read latency), a block-level scoreboard
// that predicts the emitted word order, and directed block transfers.
// Honours TRANSPOSE_EN the same way as the design.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_idct_transpose_ctrl;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'd0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_last;
  logic        out_ready = 1'b1;
  logic [5:0]  mem_addr;
  logic [15:0] mem_data_in;
  logic        mem_write_read;
  logic [15:0] mem_data_out;

`ifdef TRANSPOSE_EN
  localparam bit TR = 1'b1;
`else
  localparam bit TR = 1'b0;
`endif

  always #5 clk = ~clk;

  idct_transpose_ctrl dut (
    .clk            (clk),
    .rst_b          (rst_b),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_last       (out_last),
    .out_ready      (out_ready),
    .mem_addr       (mem_addr),
    .mem_data_in    (mem_data_in),
    .mem_write_read (mem_write_read),
    .mem_data_out   (mem_data_out)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural buffer; starts full of a marker value so stale reads show up.
  logic [15:0] mem [64];
  logic [15:0] mem_rd;
  bit          mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 16'hBEEF;
      mem_rd   <= 16'hBEEF;
      mem_init <= 1'b1;
    end else if (!mem_write_read) begin
      mem[mem_addr] <= mem_data_in;
    end else begin
      mem_rd        <= mem[mem_addr];
      mem[mem_addr] <= 16'd0;
    end
  end
  assign mem_data_out = mem_rd;

  // out_ready pattern: mode 0 always 1, mode 1 repeating 1,0,0,1.
  int ready_mode = 0;
  initial begin
    int ph;
    bit [3:0] pat;
    ph = 0;
    pat = 4'b1001;
    forever begin
      @(posedge clk);
      #1;
      out_ready = (ready_mode == 0) ? 1'b1 : pat[ph];
      ph = (ph + 1) % 4;
    end
  end

  // ---------------- scoreboard / per-cycle compare ----------------
  logic [15:0] exp_q[$];
  bit          explast_q[$];
  logic [15:0] blk_q[$];
  bit          exp_in_ready = 1'b1;
  bit          prev_stall = 1'b0;
  logic [15:0] prev_data;
  logic        prev_last;
  bit          wait_first = 1'b0;
  int          last_beat_cyc = 0;
  int          lat_meas = -1;
  int          first_out_cyc = 0;
  int          last_pop_cyc = 0;
  logic [15:0] rx [1024];
  int          rx_n = 0;

  always @(negedge clk) begin
    bit acc;
    int idx;
    logic [15:0] ed;
    bit el;
    if (!rst_b) begin
      blk_q.delete();
      exp_q.delete();
      explast_q.delete();
      exp_in_ready = 1'b1;
      prev_stall = 1'b0;
      wait_first = 1'b0;
    end else begin
      chk("in_ready", in_ready, exp_in_ready);
      acc = in_valid && in_ready;
      chk("mem_write_read", mem_write_read, !acc);
      if (acc) begin
        chk("mem_addr_write", mem_addr, blk_q.size());
        chk("mem_data_in", mem_data_in, in_data);
      end else begin
        chk("mem_data_in_idle", mem_data_in, 0);
      end
      if (!out_valid) chk("out_last_idle", out_last, 0);
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_data);
        chk("stall_last", out_last, prev_last);
      end
      if (out_valid && wait_first) begin
        lat_meas = cyc - last_beat_cyc;
        first_out_cyc = cyc;
        wait_first = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_word", out_data, 16'hFFFF);
        end else begin
          ed = exp_q.pop_front();
          el = explast_q.pop_front();
          chk("out_data", out_data, ed);
          chk("out_last", out_last, el);
          rx[rx_n % 1024] = out_data;
          rx_n++;
          if (el) begin
            exp_in_ready = 1'b1;
            last_pop_cyc = cyc;
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
      prev_last = out_last;
      if (acc) begin
        blk_q.push_back(in_data);
        if (blk_q.size() == 64) begin
          // k-th output is element (row k%8, col k/8) when transposing.
          for (int k = 0; k < 64; k++) begin
            idx = TR ? ((k % 8) * 8 + (k / 8)) : k;
            exp_q.push_back(blk_q[idx]);
            explast_q.push_back(k == 63);
          end
          blk_q.delete();
          exp_in_ready = 1'b0;
          wait_first = 1'b1;
          last_beat_cyc = cyc;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_beat(input logic [15:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data = d;
    while (!in_ready && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_block(input int base, input int nbeats, input bit gap);
    for (int i = 0; i < nbeats; i++) begin
      send_beat(16'(base + i));
      if (gap) begin
        repeat (2) begin
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_done", n < 1000, 1);
  endtask

  initial begin
    int base;
    rst_b = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    // Reset values.
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_mem_wr", mem_write_read, 1);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_din", mem_data_in, 0);
    rst_b = 1'b1;
    @(posedge clk);
    #1;

    // Block 0..63, continuous, out_ready held high.
    $display("INFO block 0..63 continuous");
    base = rx_n;
    send_block(0, 64, 1'b0);
    drain();
    chk("lit_latency", lat_meas, 3);
    chk("lit_throughput", last_pop_cyc - first_out_cyc, 63);
    chk("lit_rx0", rx[base], 0);
    chk("lit_rx1", rx[base + 1], TR ? 8 : 1);
    chk("lit_rx8", rx[base + 8], TR ? 1 : 8);
    chk("lit_rx63", rx[base + 63], 63);

    // Gapped input, stalling output.
    $display("INFO block 200..263 gapped input, out_ready 1,0,0,1");
    ready_mode = 1;
    base = rx_n;
    send_block(200, 64, 1'b1);
    drain();
    chk("lit_gap_count", rx_n - base, 64);
    chk("lit_gap_rx2", rx[base + 2], TR ? 216 : 202);
    ready_mode = 0;

    // Reset after 30 beats, then a fresh block.
    $display("INFO 30 beats, reset, block 100..163");
    send_block(0, 30, 1'b0);
    rst_b = 1'b0;
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    base = rx_n;
    send_block(100, 64, 1'b0);
    drain();
    chk("lit_rst_count", rx_n - base, 64);
    chk("lit_rst_rx0", rx[base], 100);
    chk("lit_rst_rx1", rx[base + 1], TR ? 108 : 101);
    chk("lit_rst_rx63", rx[base + 63], 163);

    // Two blocks back-to-back with stalls.
    $display("INFO blocks 300.. and 400.. back-to-back");
    ready_mode = 1;
    base = rx_n;
    send_block(300, 64, 1'b0);
    send_block(400, 64, 1'b0);
    drain();
    chk("lit_b2b_count", rx_n - base, 128);
    chk("lit_b2b_rx64", rx[base + 64], 400);
    chk("lit_b2b_rx127", rx[base + 127], 463);
    ready_mode = 0;

    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/idct_transpose_ctrl.md
IDCT_TRANSPOSE_CTRL -- requirements
Module: idct_transpose_ctrl

Interface
REQ-001 The block SHALL have the following ports (name  direction  width  meaning):
 - clk  in  1  single clock, all logic on rising edge
 - rst_b  in  1  synchronous active-low reset
 - in_valid  in  1  upstream coefficient valid
 - in_data  in  16  upstream coefficient, row-major order
 - in_ready  out  1  block accepts in_data this cycle
 - out_valid  out  1  output word valid
 - out_data  out  16  output word
 - out_last  out  1  marks the 64th word of a block
 - out_ready  in  1  downstream accepts out_data this cycle
 - mem_addr  out  6  to 64x16 buffer addr
 - mem_data_in  out  16  to buffer data_in
 - mem_write_read  out  1  to buffer write_read (0 write, 1 read)
 - mem_data_out  in  16  from buffer data_out
REQ-002 The block SHALL use one clock, clk; reset rst_b SHALL be synchronous and active-low.
REQ-003 The block SHALL have no parameters; the block size is fixed at 64 words of 16 bits.

Function
REQ-004 The FSM SHALL have two states: WRITE (fill buffer) and READ (drain buffer).
REQ-005 In WRITE: in_ready=1; an input beat is accepted when in_valid&&in_ready.
REQ-006 On an accepted beat: mem_write_read=0, mem_addr=wcnt, mem_data_in=in_data; wcnt increments by 1.
REQ-007 Any cycle without an accepted write SHALL drive mem_write_read=1, because a 0 writes the buffer unconditionally.
REQ-008 When the 64th beat is accepted (wcnt=63), the FSM SHALL move to READ on the next cycle and clear wcnt to 0; in_ready SHALL be 0 from that cycle.
REQ-009 In READ: a read is issued by driving mem_write_read=1 with mem_addr=raddr(rcnt); rcnt increments per issued read.
REQ-010 With TRANSPOSE_EN defined, raddr(rcnt) = {rcnt[2:0], rcnt[5:3]}, giving column-major order.
REQ-011 The buffer returns read data one cycle after issue and clears the location. Each issued read SHALL therefore be captured exactly once, in the cycle after issue.
REQ-012 Returned words SHALL enter a 2-entry output FIFO that drives out_valid/out_data. The FIFO head SHALL be presented with out_valid=1.
REQ-013 A read SHALL be issued only when FIFO occupancy plus in-flight reads is less than 2. Back-to-back issue SHALL be allowed, giving 1 word/cycle with out_ready held at 1.
REQ-014 While no read is issued, the block SHALL hold mem_write_read=1 and mem_addr at the last issued address, and SHALL discard the returned data.
REQ-015 out_last SHALL be 1 exactly when out_valid=1 and the head word is the 64th of the block.
REQ-016 out_valid/out_data/out_last SHALL remain stable while out_valid && !out_ready.
REQ-017 When the word with out_last=1 is accepted, the FSM SHALL return to WRITE on the next cycle with rcnt=0 and the FIFO empty; in_ready rises that cycle.
REQ-018 Total latency from the last input accepted to the first out_valid SHALL be 3 cycles: state change, issue, capture.
REQ-019 mem_data_in SHALL be 0 whenever mem_write_read=1.

Reset
REQ-020 When rst_b=0 at a clock edge, on that edge the block SHALL set:
 - state=WRITE
 - wcnt=rcnt=0
 - FIFO empty, in-flight cleared
 - in_ready=1 on the following cycle
 - out_valid=0, out_data=0, out_last=0
 - mem_addr=0, mem_data_in=0, mem_write_read=1
REQ-021 A reset mid-block SHALL discard the partial block. Stale buffer words SHALL be overwritten by the next full write pass, and no stale word SHALL be emitted.

Configuration
REQ-022 Macro TRANSPOSE_EN: when defined, read order SHALL be column-major (transpose). When undefined, raddr(rcnt)=rcnt (row-major pass-through). All other timing SHALL be identical in both builds.

Verification
REQ-023 Reset then 64 beats in_data=0..63 with in_valid held 1 and out_ready=1 (TRANSPOSE_EN) -> outputs 0,8,16,...,56,1,9,...,63 at 1/cycle; out_last on 63; first out_valid 3 cycles after the last beat.
REQ-024 Same stimulus without TRANSPOSE_EN -> outputs 0..63 in order, out_last on 63.
REQ-025 out_ready toggled 1,0,0,1 repeatedly during READ -> no word lost or duplicated; out_data held during stalls; mem_write_read never 0 in READ.
REQ-026 in_valid gapped (1 of every 3 cycles) during WRITE -> mem_write_read=0 only on accepted beats; in_ready=0 throughout READ.
REQ-027 rst_b=0 for one cycle after 30 beats, then a fresh block of 64 beats in_data=100..163 -> only 100..163 emitted (transposed); no value 0..29 appears.
REQ-028 Two blocks back-to-back -> in_ready rises the cycle after the first block's out_last is accepted; the second block is emitted correctly.
